// File: rtl/pixel_normalizer.sv
// rtl/pixel_normalizer.sv - buffers a cropped frame and streams it out scaled by full-scale / frame max
// Defining PIXEL_NORM_ROUND_EN selects round-half-up scaling; otherwise the scaled value is truncated.
module pixel_normalizer #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int OUT_ROWS        = 10,
    parameter int OUT_COLS        = 10,
    parameter int OUT_BIT_WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ap_start,
    output logic                       ap_ready,
    output logic                       ap_done,
    input  logic [PIXEL_BIT_WIDTH-1:0] max_value,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [OUT_BIT_WIDTH-1:0]   m_axis_tdata,
    output logic                       m_axis_tlast
);
    localparam int N  = OUT_ROWS * OUT_COLS;
    localparam int PW = PIXEL_BIT_WIDTH;
    localparam int OW = OUT_BIT_WIDTH;
    localparam int QW = OW + 16;
    localparam int MW = PW + QW;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);
    localparam int DW = $clog2(QW + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [CW-1:0] N_CNT     = CW'(N);
    localparam logic [CW-1:0] LAST_CNT  = CW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(QW);
    localparam logic [OW-1:0] FULL      = '1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RECIP, S_STREAM, S_DONE} state_t;
    state_t r_state, w_next;

    logic [AW-1:0] r_wr_addr;
    logic [CW-1:0] r_rd_cnt;
    logic [DW-1:0] r_div_cnt;
    logic [PW-1:0] r_max;
    logic [PW-1:0] r_rem;
    logic [QW-1:0] r_quot;
    logic [PW-1:0] r_mem [0:N-1];
    logic [PW-1:0] r_rd_data;
    logic          r_v1, r_last1, r_v2, r_last2;
    logic [MW-1:0] r_prod;
    logic          r_tvalid, r_tlast;
    logic [OW-1:0] r_tdata;

    logic          w_load_hs, w_adv, w_issue, w_out_hs, w_ge;
    logic [PW:0]   w_shift;
    logic [PW-1:0] w_diff;
    logic [MW:0]   w_biased, w_scaled;
    logic [OW-1:0] w_sat;

    assign w_load_hs = (r_state == S_LOAD) && s_axis_tvalid;
    assign w_adv     = !r_tvalid || m_axis_tready;
    assign w_issue   = (r_state == S_STREAM) && w_adv && (r_rd_cnt != N_CNT);
    assign w_out_hs  = r_tvalid && m_axis_tready;

    // Restoring divider: dividend shifts out of r_quot's top while quotient bits enter at the bottom.
    assign w_shift = {r_rem, r_quot[QW-1]};
    assign w_ge    = (r_max != '0) && (w_shift >= {1'b0, r_max});
    assign w_diff  = w_shift[PW-1:0] - r_max;

`ifdef PIXEL_NORM_ROUND_EN
    assign w_biased = {1'b0, r_prod} + (MW+1)'(32768);
`else
    assign w_biased = {1'b0, r_prod};
`endif
    assign w_scaled = w_biased >> 16;
    assign w_sat    = (|w_scaled[MW:OW]) ? FULL : w_scaled[OW-1:0];

    always_comb begin
        w_next        = r_state;
        ap_ready      = 1'b0;
        ap_done       = 1'b0;
        s_axis_tready = 1'b0;
        case (r_state)
            S_IDLE: begin
                ap_ready = 1'b1;
                if (ap_start) w_next = S_LOAD;
            end
            S_LOAD: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && r_wr_addr == LAST_ADDR) w_next = S_RECIP;
            end
            S_RECIP:  if (r_div_cnt == DIV_LAST) w_next = S_STREAM;
            S_STREAM: if (w_out_hs && r_tlast) w_next = S_DONE;
            S_DONE: begin
                ap_done = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_wr_addr <= '0;
            r_rd_cnt  <= '0;
            r_div_cnt <= '0;
            r_max     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_v1      <= 1'b0;
            r_last1   <= 1'b0;
            r_v2      <= 1'b0;
            r_last2   <= 1'b0;
            r_prod    <= '0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_tdata   <= '0;
        end else begin
            r_state <= w_next;
            if (w_load_hs)
                r_wr_addr <= (r_wr_addr == LAST_ADDR) ? '0 : r_wr_addr + AW'(1);
            if (r_state == S_RECIP) begin
                r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DW'(1);
                if (r_div_cnt == '0) begin
                    r_max  <= max_value;
                    r_rem  <= '0;
                    r_quot <= {FULL, 16'd0};
                end else begin
                    r_rem  <= w_ge ? w_diff : w_shift[PW-1:0];
                    r_quot <= {r_quot[QW-2:0], w_ge};
                end
            end
            // Leaving STREAM (normally or via DONE) flushes the pipeline so no stale beat survives.
            if (r_state != S_STREAM) begin
                r_rd_cnt <= '0;
                r_v1     <= 1'b0;
                r_last1  <= 1'b0;
                r_v2     <= 1'b0;
                r_last2  <= 1'b0;
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end else if (w_adv) begin
                if (w_issue) r_rd_cnt <= r_rd_cnt + CW'(1);
                r_v1     <= w_issue;
                r_last1  <= w_issue && (r_rd_cnt == LAST_CNT);
                r_v2     <= r_v1;
                r_last2  <= r_last1;
                r_prod   <= MW'(r_rd_data) * MW'(r_quot);
                r_tvalid <= r_v2;
                r_tlast  <= r_v2 && r_last2;
                if (r_v2) r_tdata <= w_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load_hs) r_mem[r_wr_addr] <= s_axis_tdata;
        if (w_issue)   r_rd_data <= r_mem[r_rd_cnt[AW-1:0]];
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tlast  = r_tlast;
endmodule

// File: tb/tb_pixel_normalizer.sv
// tb/tb_pixel_normalizer.sv - self-checking bench for pixel_normalizer (honours PIXEL_NORM_ROUND_EN)
module tb_pixel_normalizer;
    localparam int PW = 10, OW = 8, ROWS = 10, COLS = 10;
    localparam int N = ROWS * COLS, FULLV = 255, RECIP_CYC = OW + 17;

    logic          clk = 1'b0;
    logic          reset, ap_start, ap_ready, ap_done;
    logic [PW-1:0] max_value, s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [OW-1:0] m_axis_tdata;

    int n_vec = 0, n_bad = 0, done_cnt = 0;
    int pix[N];

    typedef struct { int maxv; int pixv; int exp_t; int exp_r; } vec_t;
    vec_t tbl[9];

    pixel_normalizer #(.PIXEL_BIT_WIDTH(PW), .OUT_ROWS(ROWS), .OUT_COLS(COLS), .OUT_BIT_WIDTH(OW)) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .max_value(max_value), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (!reset && ap_done) done_cnt <= done_cnt + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model(input int m, input int p);
        longint r, v;
        if (m == 0) return 0;
        r = (longint'(FULLV) << 16) / m;
        v = p * r;
`ifdef PIXEL_NORM_ROUND_EN
        v = v + 32768;
`endif
        v = v >>> 16;
        return (v > FULLV) ? FULLV : int'(v);
    endfunction

    task automatic run_frame(input int maxv, input bit rand_rdy, input bit noise,
                             input int tbl_exp, input int abort_at);
        int idx, cyc, beat, lat, done0, bad_rdy, bad_hold;
        bit vld, rdy, stalled;
        logic [OW-1:0] held_d;
        logic held_l;
        done0 = done_cnt;
        held_d = '0;
        held_l = 1'b0;
        check("idle_ap_ready", ap_ready, 1);
        ap_start = 1'b1;
        max_value = PW'(maxv);
        @(negedge clk);
        ap_start = 1'b0;
        check("load_tready", s_axis_tready, 1);
        check("load_ap_ready", ap_ready, 0);
        idx = 0;
        cyc = 0;
        while (idx < N && cyc < 1000) begin
            if (abort_at == idx) begin
                s_axis_tvalid = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
                check("abort_idle_ready", ap_ready, 1);
                return;
            end
            vld = ($urandom_range(0, 3) != 0);
            s_axis_tvalid = vld;
            s_axis_tdata = PW'(pix[idx]);
            rdy = s_axis_tready;
            @(negedge clk);
            if (vld && rdy) idx++;
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        check("load_complete", idx, N);

        lat = 0;
        bad_rdy = 0;
        while (!m_axis_tvalid && lat < 200) begin
            if (noise) begin
                ap_start = 1'b1;
                s_axis_tvalid = 1'b1;
            end
            if (s_axis_tready || ap_ready) bad_rdy++;
            @(negedge clk);
            lat++;
        end
        check("first_beat_latency", lat, RECIP_CYC + 3);
        max_value = PW'($urandom_range(0, 1023));

        beat = 0;
        cyc = 0;
        stalled = 1'b0;
        bad_hold = 0;
        while (beat < N && cyc < 3000) begin
            if (noise) begin
                ap_start = 1'($urandom_range(0, 1));
                s_axis_tvalid = 1'b1;
                if (s_axis_tready || ap_ready) bad_rdy++;
            end
            rdy = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            m_axis_tready = rdy;
            if (stalled && (!m_axis_tvalid || m_axis_tdata != held_d || m_axis_tlast != held_l))
                bad_hold++;
            if (m_axis_tvalid && rdy) begin
                check("beat_data", m_axis_tdata, model(maxv, pix[beat]));
                check("beat_tlast", m_axis_tlast, (beat == N - 1) ? 1 : 0);
                if (beat == 0 && tbl_exp >= 0) check("table_expected", m_axis_tdata, tbl_exp);
                beat++;
            end
            stalled = m_axis_tvalid && !rdy;
            held_d = m_axis_tdata;
            held_l = m_axis_tlast;
            @(negedge clk);
            cyc++;
        end
        m_axis_tready = 1'b0;
        ap_start = 1'b0;
        s_axis_tvalid = 1'b0;
        check("beats_received", beat, N);
        if (!rand_rdy) check("stream_cycles", cyc, N);
        check("no_ready_outside_idle_load", bad_rdy, 0);
        check("stall_hold", bad_hold, 0);
        check("done_pulse_now", ap_done, 1);
        @(negedge clk);
        check("done_pulse_width", ap_done, 0);
        check("back_idle", ap_ready, 1);
        check("no_extra_valid", m_axis_tvalid, 0);
        check("done_count", done_cnt - done0, 1);
    endtask

    initial begin
        int e, d0, bad, mv;
        tbl[0] = '{512, 512, 255, 255};
        tbl[1] = '{512, 256, 127, 128};
        tbl[2] = '{512, 0, 0, 0};
        tbl[3] = '{1023, 1023, 254, 255};
        tbl[4] = '{0, 777, 0, 0};
        tbl[5] = '{1, 1023, 255, 255};
        tbl[6] = '{3, 1, 85, 85};
        tbl[7] = '{1023, 1, 0, 0};
        tbl[8] = '{700, 350, 127, 127};

        reset = 1'b1;
        ap_start = 1'b0;
        max_value = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ap_ready", ap_ready, 1);
        check("rst_ap_done", ap_done, 0);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        check("rst_m_tlast", m_axis_tlast, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 9; t++) begin
            for (int i = 0; i < N; i++) pix[i] = $urandom_range(0, 1023);
            pix[0] = tbl[t].pixv;
`ifdef PIXEL_NORM_ROUND_EN
            e = tbl[t].exp_r;
`else
            e = tbl[t].exp_t;
`endif
            run_frame(tbl[t].maxv, 1'b0, 1'b0, e, -1);
        end

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) pix[i] = $urandom_range(0, 1023);
            mv = (r == 2) ? $urandom_range(1, 8) : $urandom_range(0, 1023);
            run_frame(mv, 1'b1, r[0], -1, -1);
        end

        for (int i = 0; i < N; i++) pix[i] = $urandom_range(0, 1023);
        run_frame(600, 1'b0, 1'b0, -1, 50);
        d0 = done_cnt;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (m_axis_tvalid || s_axis_tready) bad++;
            @(negedge clk);
        end
        check("abort_quiet", bad, 0);
        check("abort_no_done", done_cnt - d0, 0);
        for (int i = 0; i < N; i++) pix[i] = $urandom_range(0, 1023);
        run_frame(900, 1'b1, 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pixel_normalizer.md
PIXEL_NORMALIZER -- requirements
Module: pixel_normalizer

Interface
REQ-001 SHALL have parameter PIXEL_BIT_WIDTH, default 10: input pixel width.
REQ-002 SHALL have parameter OUT_ROWS, default 10: cropped frame rows.
REQ-003 SHALL have parameter OUT_COLS, default 10: cropped frame columns; N = OUT_ROWS*OUT_COLS.
REQ-004 SHALL have parameter OUT_BIT_WIDTH, default 8: normalized output width; full scale F = 2^OUT_BIT_WIDTH-1.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ap_start  in  1  frame start request.
- ap_ready  out  1  ready to accept ap_start.
- ap_done  out  1  one-cycle pulse, frame fully emitted.
- max_value  in  PIXEL_BIT_WIDTH  frame maximum from the crop stage.
- s_axis_tvalid  in  1  cropped-pixel valid.
- s_axis_tready  out  1  cropped-pixel ready.
- s_axis_tdata  in  PIXEL_BIT_WIDTH  cropped pixel.
- m_axis_tvalid  out  1  normalized-pixel valid.
- m_axis_tready  in  1  normalized-pixel ready.
- m_axis_tdata  out  OUT_BIT_WIDTH  normalized pixel.
- m_axis_tlast  out  1  marks the N-th output beat.

Function
REQ-006 SHALL implement FSM IDLE -> LOAD -> RECIP -> STREAM -> DONE -> IDLE.
REQ-007 IDLE: ap_ready=1; ap_start=1 SHALL transition to LOAD next cycle; ap_ready SHALL be 0 in every other state.
REQ-008 LOAD: s_axis_tready=1; each handshake SHALL write s_axis_tdata to an N-entry frame buffer at a write address counting 0..N-1.
REQ-009 The handshake at address N-1 SHALL transition to RECIP; s_axis_tready SHALL be 0 outside LOAD.
REQ-010 RECIP cycle 1 SHALL latch max_value into an internal register M.
REQ-011 RECIP SHALL then compute R = floor(F*2^16 / M) with a 1-bit-per-cycle restoring divider.
REQ-012 RECIP SHALL last exactly OUT_BIT_WIDTH+17 cycles, then transition to STREAM.
REQ-013 M=0 SHALL yield R=0, giving all outputs 0; no divide fault SHALL occur.
REQ-014 STREAM SHALL read the buffer in write order and compute P = (pixel*R) >> 16, saturated to F.
REQ-015 STREAM pipeline SHALL be: buffer read (1 cycle) -> multiply register -> output register.
REQ-016 Latency from STREAM entry to the first m_axis_tvalid=1 SHALL be 3 cycles.
REQ-017 The output beat SHALL be AXI-compliant: once m_axis_tvalid=1, tvalid, tdata and tlast SHALL hold until m_axis_tready=1.
REQ-018 The whole pipeline SHALL stall while m_axis_tvalid=1 and m_axis_tready=0, with no beat lost or duplicated.
REQ-019 With continuous m_axis_tready=1, the block SHALL sustain one beat per cycle.
REQ-020 m_axis_tlast SHALL be 1 only on beat N-1.
REQ-021 Handshake of the tlast beat SHALL transition to DONE; DONE SHALL assert ap_done for exactly one cycle and then return to IDLE.
REQ-022 ap_start outside IDLE SHALL be ignored.
REQ-023 s_axis_tvalid outside LOAD SHALL be ignored and no data consumed.
REQ-024 Buffer and pipeline SHALL infer block RAM (synchronous read, no reset on contents).

Reset
REQ-025 reset SHALL force: IDLE, ap_ready=1, ap_done=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, all counters=0, M=0, R=0.
REQ-026 reset mid-LOAD, mid-RECIP or mid-STREAM SHALL abandon the frame with no further output beats; the next frame SHALL start cleanly from ap_start.

Configuration
REQ-027 Macro PIXEL_NORM_ROUND_EN defined: P = (pixel*R + 2^15) >> 16, saturated to F (round-half-up).
REQ-028 Macro PIXEL_NORM_ROUND_EN undefined: P = (pixel*R) >> 16 (truncate); all timing is identical in both builds.

Verification (OUT_BIT_WIDTH=8, PIXEL_BIT_WIDTH=10, N=100)
REQ-029 max_value=512; pixels 512, 256, 0 -> R=32640; outputs 255, 127, 0 truncating; 255, 128, 0 with PIXEL_NORM_ROUND_EN.
REQ-030 max_value=1023, pixel 1023 -> R=16335; output 254 truncating, 255 rounded.
REQ-031 max_value=0, any 100 pixels -> 100 output beats all 0, tlast on beat 100, ap_done one cycle later.
REQ-032 m_axis_tready toggled randomly during STREAM -> output sequence identical to tready=1 run; tdata stable while stalled.
REQ-033 reset asserted at beat 50 of LOAD, then a full new frame -> no stale output; second frame correct, ap_done pulses exactly once.
REQ-034 ap_start pulsed during RECIP/STREAM, s_axis_tvalid=1 during STREAM -> no state change, s_axis_tready stays 0.
